hci_core_load_buffer: RTL and testbench

- Sits between a streamer load port (e.g. the core source) and the TCDM interconnect, on the tcdm side of the streamer.
- Forwards load requests downstream and captures every response in a local response FIFO.
- The upstream consumer may deassert lrdy without losing data, because the memory side can never stall r_valid.
- Credit-based: a request is issued only if a FIFO slot is reserved for its response.

---
 rtl/hci_core_load_buffer_pkg.sv | 23 ++
 rtl/hci_core_load_buffer_fifo.sv | 71 +++++++
 rtl/hci_core_load_buffer.sv | 116 +++++++++++
 tb/tb_hci_core_load_buffer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hci_core_load_buffer_pkg.sv
// Shared types and helpers for the HCI core load buffer.
// Flags bundle and circular-pointer increment used by the buffer and its FIFO.
package hci_core_load_buffer_pkg;

   localparam int unsigned LB_DEPTH_DEF = 4;
   localparam int unsigned LB_CW_DEF    = $clog2(LB_DEPTH_DEF + 1);

   typedef struct packed {
      logic [LB_CW_DEF-1:0] occupancy;
      logic [LB_CW_DEF-1:0] outstanding;
      logic                 idle;
      logic                 err;
   } hci_load_buffer_flags_t;

   // Explicit wrap so DEPTH need not be a power of two.
   function automatic int unsigned lb_next_ptr(
      input int unsigned ptr,
      input int unsigned depth
   );
      return (ptr >= depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/hci_core_load_buffer_fifo.sv
// Register-based circular response buffer, DEPTH x DATA_WIDTH.
// Push is never back-pressured; the owner guarantees a free slot.
module hci_core_load_buffer_fifo
   import hci_core_load_buffer_pkg::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CW         = $clog2(DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [CW-1:0]         count_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         head_q;
   logic [PW-1:0]         tail_q;
   logic [PW-1:0]         head_n;
   logic [PW-1:0]         tail_n;
   logic [CW-1:0]         count_q;
   logic [CW-1:0]         count_n;

   always_comb begin
      head_n  = PW'(lb_next_ptr(32'(head_q), DEPTH));
      tail_n  = PW'(lb_next_ptr(32'(tail_q), DEPTH));
      count_n = count_q;
      unique case ({push_i, pop_i})
         2'b10:   count_n = count_q + CW'(1);
         2'b01:   count_n = count_q - CW'(1);
         default: count_n = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (clear_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_i) begin
            tail_q <= tail_n;
         end
         if (pop_i) begin
            head_q <= head_n;
         end
         count_q <= count_n;
      end
   end

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[tail_q] <= data_i;
      end
   end

   assign data_o  = mem_q[head_q];
   assign count_o = count_q;

endmodule

// File: rtl/hci_core_load_buffer.sv
// Credit-based load buffer between a streamer load port and the TCDM.
// Requests issue only when a response slot is reserved in the local FIFO.
module hci_core_load_buffer
   import hci_core_load_buffer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned CW         = $clog2(DEPTH + 1)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    clear_i,
   input  logic                    enable_i,
   input  logic                    tgt_req_i,
   input  logic [ADDR_WIDTH-1:0]   tgt_add_i,
   output logic                    tgt_gnt_o,
   output logic [DATA_WIDTH-1:0]   tgt_r_data_o,
   output logic                    tgt_r_valid_o,
   input  logic                    tgt_lrdy_i,
   output logic                    ini_req_o,
   output logic [ADDR_WIDTH-1:0]   ini_add_o,
   output logic                    ini_wen_o,
   output logic [DATA_WIDTH/8-1:0] ini_be_o,
   output logic [DATA_WIDTH-1:0]   ini_data_o,
   input  logic                    ini_gnt_i,
   input  logic [DATA_WIDTH-1:0]   ini_r_data_i,
   input  logic                    ini_r_valid_i,
   output logic                    ini_lrdy_o,
   output logic [CW-1:0]           occupancy_o,
   output logic [CW-1:0]           outstanding_o,
   output logic                    idle_o,
   output logic                    err_o
);

   logic [CW-1:0] occ_q;
   logic [CW-1:0] out_q;
   logic [CW-1:0] out_n;
   logic [CW:0]   used_q;
   logic          credit_ok;
   logic          issue;
   logic          has_out;
   logic          retire;
   logic          spurious;
   logic          push;
   logic          pop;
   logic          err_q;

   // Credit uses registered counts only; a pop frees a slot next cycle.
   assign used_q    = {1'b0, occ_q} + {1'b0, out_q};
   assign credit_ok = used_q < (CW + 1)'(DEPTH);

   assign ini_req_o  = enable_i & tgt_req_i & credit_ok;
   assign ini_add_o  = tgt_add_i;
   assign tgt_gnt_o  = ini_req_o & ini_gnt_i;
   assign ini_wen_o  = 1'b1;
   assign ini_be_o   = '0;
   assign ini_data_o = '0;
   assign ini_lrdy_o = 1'b1;

   assign issue    = ini_req_o & ini_gnt_i;
   assign has_out  = out_q != '0;
   assign retire   = ini_r_valid_i & has_out;
   assign spurious = ini_r_valid_i & ~has_out;

   // A tracked response always has a reserved slot; a stray one only if free.
   assign push = retire | (spurious & (occ_q != CW'(DEPTH)));

   assign tgt_r_valid_o = enable_i & (occ_q != '0);
   assign pop           = tgt_r_valid_o & tgt_lrdy_i;

   always_comb begin
      out_n = out_q;
      unique case ({issue, retire})
         2'b10:   out_n = out_q + CW'(1);
         2'b01:   out_n = out_q - CW'(1);
         default: out_n = out_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         out_q <= '0;
         err_q <= 1'b0;
      end else if (clear_i) begin
         out_q <= '0;
         err_q <= 1'b0;
      end else begin
         out_q <= out_n;
         if (spurious) begin
            err_q <= 1'b1;
         end
      end
   end

   hci_core_load_buffer_fifo #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .CW         (CW)
   ) i_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .push_i  (push),
      .data_i  (ini_r_data_i),
      .pop_i   (pop),
      .data_o  (tgt_r_data_o),
      .count_o (occ_q)
   );

   assign occupancy_o   = occ_q;
   assign outstanding_o = out_q;
   assign idle_o        = (occ_q == '0) & (out_q == '0);
   assign err_o         = err_q;

endmodule

// File: tb/tb_hci_core_load_buffer.sv
// Directed self-checking bench for hci_core_load_buffer.
// Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
module tb_hci_core_load_buffer;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int DP = 4;
   localparam int CW = 3;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            clear_i;
   logic            enable_i;
   logic            tgt_req_i;
   logic [AW-1:0]   tgt_add_i;
   logic            tgt_gnt_o;
   logic [DW-1:0]   tgt_r_data_o;
   logic            tgt_r_valid_o;
   logic            tgt_lrdy_i;
   logic            ini_req_o;
   logic [AW-1:0]   ini_add_o;
   logic            ini_wen_o;
   logic [DW/8-1:0] ini_be_o;
   logic [DW-1:0]   ini_data_o;
   logic            ini_gnt_i;
   logic [DW-1:0]   ini_r_data_i;
   logic            ini_r_valid_i;
   logic            ini_lrdy_o;
   logic [CW-1:0]   occupancy_o;
   logic [CW-1:0]   outstanding_o;
   logic            idle_o;
   logic            err_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   hci_core_load_buffer #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DEPTH      (DP)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .clear_i       (clear_i),
      .enable_i      (enable_i),
      .tgt_req_i     (tgt_req_i),
      .tgt_add_i     (tgt_add_i),
      .tgt_gnt_o     (tgt_gnt_o),
      .tgt_r_data_o  (tgt_r_data_o),
      .tgt_r_valid_o (tgt_r_valid_o),
      .tgt_lrdy_i    (tgt_lrdy_i),
      .ini_req_o     (ini_req_o),
      .ini_add_o     (ini_add_o),
      .ini_wen_o     (ini_wen_o),
      .ini_be_o      (ini_be_o),
      .ini_data_o    (ini_data_o),
      .ini_gnt_i     (ini_gnt_i),
      .ini_r_data_i  (ini_r_data_i),
      .ini_r_valid_i (ini_r_valid_i),
      .ini_lrdy_o    (ini_lrdy_o),
      .occupancy_o   (occupancy_o),
      .outstanding_o (outstanding_o),
      .idle_o        (idle_o),
      .err_o         (err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst_ni        = 1'b0;
      clear_i       = 1'b0;
      enable_i      = 1'b1;
      tgt_req_i     = 1'b0;
      tgt_add_i     = '0;
      tgt_lrdy_i    = 1'b0;
      ini_gnt_i     = 1'b0;
      ini_r_data_i  = '0;
      ini_r_valid_i = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
      settle();
      chk("rst_gnt", 32'(tgt_gnt_o), 0);
      chk("rst_rvalid", 32'(tgt_r_valid_o), 0);
      chk("rst_ireq", 32'(ini_req_o), 0);
      chk("rst_idle", 32'(idle_o), 1);
      chk("rst_err", 32'(err_o), 0);
      chk("rst_occ", 32'(occupancy_o), 0);
      chk("rst_out", 32'(outstanding_o), 0);
      chk("tie_wen", 32'(ini_wen_o), 1);
      chk("tie_lrdy", 32'(ini_lrdy_o), 1);
      chk("tie_be", 32'(ini_be_o), 0);

      // 1: single load
      tgt_req_i  = 1'b1;
      tgt_add_i  = 32'h100;
      ini_gnt_i  = 1'b1;
      tgt_lrdy_i = 1'b1;
      settle();
      chk("t1_gnt", 32'(tgt_gnt_o), 1);
      chk("t1_add", ini_add_o, 32'h100);
      tick();
      tgt_req_i     = 1'b0;
      ini_r_valid_i = 1'b1;
      ini_r_data_i  = 32'hCAFE0001;
      settle();
      chk("t1_out1", 32'(outstanding_o), 1);
      chk("t1_nobypass", 32'(tgt_r_valid_o), 0);
      tick();
      ini_r_valid_i = 1'b0;
      settle();
      chk("t1_rvalid", 32'(tgt_r_valid_o), 1);
      chk("t1_data", tgt_r_data_o, 32'hCAFE0001);
      tick();
      chk("t1_idle", 32'(idle_o), 1);

      // 2: back-to-back with lrdy low, credit exhaustion
      tgt_lrdy_i = 1'b0;
      tgt_req_i  = 1'b1;
      ini_gnt_i  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tgt_add_i     = 32'h200 + 32'(i);
         ini_r_valid_i = (i > 0);
         ini_r_data_i  = 32'hD0 + 32'(i) - 32'd1;
         settle();
         chk("t2_gnt", 32'(tgt_gnt_o), 1);
         tick();
      end
      tgt_add_i     = 32'h204;
      ini_r_valid_i = 1'b1;
      ini_r_data_i  = 32'hD3;
      settle();
      chk("t2_hold_req", 32'(ini_req_o), 0);
      chk("t2_hold_gnt", 32'(tgt_gnt_o), 0);
      tick();
      ini_r_valid_i = 1'b0;
      tgt_lrdy_i    = 1'b1;
      settle();
      chk("t2_occ4", 32'(occupancy_o), 4);
      chk("t2_out0", 32'(outstanding_o), 0);
      chk("t2_req_popcyc", 32'(ini_req_o), 0);
      chk("t2_d0", tgt_r_data_o, 32'hD0);
      tick();
      settle();
      chk("t2_gnt5", 32'(tgt_gnt_o), 1);
      chk("t2_d1", tgt_r_data_o, 32'hD1);
      tick();
      tgt_req_i     = 1'b0;
      ini_r_valid_i = 1'b1;
      ini_r_data_i  = 32'hD4;
      settle();
      chk("t2_d2", tgt_r_data_o, 32'hD2);
      chk("t2_out1", 32'(outstanding_o), 1);
      tick();
      ini_r_valid_i = 1'b0;
      settle();
      chk("t2_d3", tgt_r_data_o, 32'hD3);
      chk("t2_occ2", 32'(occupancy_o), 2);
      tick();
      chk("t2_d4", tgt_r_data_o, 32'hD4);
      chk("t2_v4", 32'(tgt_r_valid_o), 1);
      tick();
      chk("t2_idle", 32'(idle_o), 1);

      // 3: interconnect stall
      tgt_req_i = 1'b1;
      tgt_add_i = 32'h300;
      ini_gnt_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("t3_gnt0", 32'(tgt_gnt_o), 0);
         chk("t3_req", 32'(ini_req_o), 1);
         chk("t3_add", ini_add_o, 32'h300);
         tick();
      end
      ini_gnt_i = 1'b1;
      settle();
      chk("t3_gnt4", 32'(tgt_gnt_o), 1);
      tick();
      chk("t3_out1", 32'(outstanding_o), 1);

      // 4: issue + capture + pop at occupancy 1 / outstanding 1
      tgt_add_i     = 32'h304;
      ini_r_valid_i = 1'b1;
      ini_r_data_i  = 32'hE0;
      tick();
      tgt_add_i    = 32'h308;
      ini_r_data_i = 32'hE1;
      settle();
      chk("t4_occ1", 32'(occupancy_o), 1);
      chk("t4_out1", 32'(outstanding_o), 1);
      chk("t4_e0", tgt_r_data_o, 32'hE0);
      tick();
      tgt_req_i    = 1'b0;
      ini_r_data_i = 32'hE2;
      settle();
      chk("t4_occ_keep", 32'(occupancy_o), 1);
      chk("t4_out_keep", 32'(outstanding_o), 1);
      chk("t4_e1", tgt_r_data_o, 32'hE1);
      tick();
      ini_r_valid_i = 1'b0;
      settle();
      chk("t4_e2", tgt_r_data_o, 32'hE2);
      chk("t4_out0", 32'(outstanding_o), 0);
      tick();
      chk("t4_idle", 32'(idle_o), 1);

      // 5: enable low freezes issue and pop, capture continues
      tgt_req_i = 1'b1;
      tgt_add_i = 32'h400;
      tick();
      tgt_add_i = 32'h404;
      tick();
      enable_i      = 1'b0;
      ini_r_valid_i = 1'b1;
      ini_r_data_i  = 32'hF0;
      settle();
      chk("t5_out2", 32'(outstanding_o), 2);
      chk("t5_noreq", 32'(ini_req_o), 0);
      tick();
      ini_r_data_i = 32'hF1;
      tick();
      ini_r_valid_i = 1'b0;
      tgt_req_i     = 1'b0;
      settle();
      chk("t5_occ2", 32'(occupancy_o), 2);
      chk("t5_rv0", 32'(tgt_r_valid_o), 0);
      tick();
      chk("t5_occ_frozen", 32'(occupancy_o), 2);
      enable_i = 1'b1;
      settle();
      chk("t5_rv1", 32'(tgt_r_valid_o), 1);
      chk("t5_f0", tgt_r_data_o, 32'hF0);
      tick();
      chk("t5_f1", tgt_r_data_o, 32'hF1);
      tick();
      chk("t5_idle", 32'(idle_o), 1);

      // 6: spurious response, clear, mid-burst reset
      tgt_lrdy_i    = 1'b0;
      ini_r_valid_i = 1'b1;
      ini_r_data_i  = 32'h99;
      tick();
      ini_r_valid_i = 1'b0;
      settle();
      chk("t6_err", 32'(err_o), 1);
      chk("t6_occ1", 32'(occupancy_o), 1);
      chk("t6_out0", 32'(outstanding_o), 0);
      tick();
      chk("t6_sticky", 32'(err_o), 1);
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      settle();
      chk("t6_clr_err", 32'(err_o), 0);
      chk("t6_clr_idle", 32'(idle_o), 1);
      tgt_req_i = 1'b1;
      tgt_add_i = 32'h500;
      tick();
      tick();
      ini_r_valid_i = 1'b1;
      ini_r_data_i  = 32'h55;
      tick();
      ini_r_valid_i = 1'b0;
      tgt_req_i     = 1'b0;
      settle();
      chk("t6_pre_occ", 32'(occupancy_o), 1);
      chk("t6_pre_out", 32'(outstanding_o), 2);
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      settle();
      chk("t6_rst_occ", 32'(occupancy_o), 0);
      chk("t6_rst_out", 32'(outstanding_o), 0);
      chk("t6_rst_rv", 32'(tgt_r_valid_o), 0);
      chk("t6_rst_idle", 32'(idle_o), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
